// File: rtl/rsa_pkg.sv
// ---------------------------------------------------------------------------
// rsa_pkg
// Shared constants and types for the RSA operand memories and the blocks that
// read and write them.
//   WIDTH      : data word width in bits
//   ADDR_WIDTH : operand memory address width
//   NUM_WORDS  : words per operand (128 x 32 = 4096 bits)
//   SEL_M/SEL_E: encoding of the target-memory select
//   state_t    : writer FSM states
// ---------------------------------------------------------------------------
package rsa_pkg;

  localparam int WIDTH      = 32;
  localparam int ADDR_WIDTH = 7;
  localparam int NUM_WORDS  = 128;

  localparam logic SEL_M = 1'b0;
  localparam logic SEL_E = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/rsa_operand_writer_if.sv
// ---------------------------------------------------------------------------
// rsa_operand_writer_if
// Bundles the operand stream handshake, the memory write port and the status
// flags of the operand writer.
//   start, sel          : load request and target memory (0 = m, 1 = e)
//   in_valid, in_data   : operand word stream from the producer
//   in_ready            : writer accepts a word this cycle
//   wr_en_m, wr_en_e    : write strobes into mem_m / mem_e
//   wr_addr, wr_data    : shared write address and data
//   busy, done          : status (busy while loading, done one-cycle pulse)
//   checksum            : XOR of accepted words, only present when
//                         RSA_OPERAND_WRITER_CHECKSUM_EN is defined
// Modports: master = producer side, slave = the writer itself.
// ---------------------------------------------------------------------------
interface rsa_operand_writer_if
  import rsa_pkg::*;
#(
  parameter int WIDTH      = rsa_pkg::WIDTH,
  parameter int ADDR_WIDTH = rsa_pkg::ADDR_WIDTH
);

  logic                  start;
  logic                  sel;
  logic                  in_valid;
  logic [WIDTH-1:0]      in_data;
  logic                  in_ready;
  logic                  wr_en_m;
  logic                  wr_en_e;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [WIDTH-1:0]      wr_data;
  logic                  busy;
  logic                  done;

`ifdef RSA_OPERAND_WRITER_CHECKSUM_EN
  logic [WIDTH-1:0]      checksum;

  modport master (
    output start, sel, in_valid, in_data,
    input  in_ready, wr_en_m, wr_en_e, wr_addr, wr_data, busy, done, checksum
  );

  modport slave (
    input  start, sel, in_valid, in_data,
    output in_ready, wr_en_m, wr_en_e, wr_addr, wr_data, busy, done, checksum
  );
`else
  modport master (
    output start, sel, in_valid, in_data,
    input  in_ready, wr_en_m, wr_en_e, wr_addr, wr_data, busy, done
  );

  modport slave (
    input  start, sel, in_valid, in_data,
    output in_ready, wr_en_m, wr_en_e, wr_addr, wr_data, busy, done
  );
`endif

endinterface

// File: rtl/rsa_operand_writer.sv
// ---------------------------------------------------------------------------
// rsa_operand_writer
// Loads one multi-word operand, least-significant word first, from a
// valid/ready word stream into either the m or the e operand memory, and
// pulses done once the last word has been written.
//
// Ports:
//   clk    : clock, everything on the rising edge
//   reset  : synchronous, active-high
//   bus    : rsa_operand_writer_if.slave (stream in, memory write port out,
//            busy/done status, optional checksum)
//
// Optional feature macro: RSA_OPERAND_WRITER_CHECKSUM_EN
//   When defined, bus.checksum carries the XOR of all words accepted in the
//   current operand; it is cleared on start and held after done.
//
// Timing: a word accepted in cycle N is written in cycle N+1 (address = word
// index). After the last acceptance there is one FLUSH cycle for that write,
// then one DONE cycle with done=1, then back to IDLE.
// ---------------------------------------------------------------------------
module rsa_operand_writer #(
  parameter int WIDTH      = rsa_pkg::WIDTH,
  parameter int ADDR_WIDTH = rsa_pkg::ADDR_WIDTH,
  parameter int NUM_WORDS  = rsa_pkg::NUM_WORDS
) (
  input  logic                clk,
  input  logic                reset,
  rsa_operand_writer_if.slave bus
);

  import rsa_pkg::*;

  // Index of the final word; the counter stops here instead of wrapping.
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_WORDS - 1);

  state_t                state;
  state_t                state_nx;

  logic [ADDR_WIDTH-1:0] count;
  logic                  sel_q;
  logic                  wr_en_m_q;
  logic                  wr_en_e_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [WIDTH-1:0]      wr_data_q;

  logic                  start_acc;
  logic                  accept;
  logic                  last_word;

  // start is only honoured in IDLE; a word is only taken in LOAD, so a word
  // offered in the same cycle as start is never consumed.
  assign start_acc = (state == IDLE) && bus.start;
  assign accept    = (state == LOAD) && bus.in_valid;
  assign last_word = (count == LAST_IDX);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic: IDLE -> LOAD on start, LOAD -> FLUSH on the last
  // accepted word, then a single FLUSH and a single DONE cycle.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start_acc) state_nx = LOAD;
      LOAD:    if (accept && last_word) state_nx = FLUSH;
      FLUSH:   state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Status outputs decode directly from the state so they are glitch-free
  // relative to the state register and zero in reset.
  always_comb begin
    bus.in_ready = 1'b0;
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    case (state)
      IDLE:  ;
      LOAD: begin
        bus.in_ready = 1'b1;
        bus.busy     = 1'b1;
      end
      FLUSH: bus.busy = 1'b1;
      DONE: begin
        bus.busy = 1'b1;
        bus.done = 1'b1;
      end
      default: ;
    endcase
  end

  // Word counter and latched memory select. The select is captured only
  // with an accepted start, so later changes on sel cannot redirect the
  // remaining words of an operand.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      sel_q <= SEL_M;
    end else if (start_acc) begin
      count <= '0;
      sel_q <= bus.sel;
    end else if (accept && !last_word) begin
      count <= count + ADDR_WIDTH'(1);
    end
  end

  // Registered write port. Exactly one strobe follows each accepted word;
  // reset clears the strobes so a write in flight is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en_m_q <= 1'b0;
      wr_en_e_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_m_q <= accept && (sel_q == SEL_M);
      wr_en_e_q <= accept && (sel_q == SEL_E);
      if (accept) begin
        wr_addr_q <= count;
        wr_data_q <= bus.in_data;
      end
    end
  end

  assign bus.wr_en_m = wr_en_m_q;
  assign bus.wr_en_e = wr_en_e_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;

`ifdef RSA_OPERAND_WRITER_CHECKSUM_EN
  logic [WIDTH-1:0] checksum_q;

  // Running XOR of the accepted words. It is complete one cycle after the
  // last acceptance and therefore already settled in the DONE cycle; it then
  // holds until the next accepted start.
  always_ff @(posedge clk) begin
    if (reset) begin
      checksum_q <= '0;
    end else if (start_acc) begin
      checksum_q <= '0;
    end else if (accept) begin
      checksum_q <= checksum_q ^ bus.in_data;
    end
  end

  assign bus.checksum = checksum_q;
`endif

endmodule

// File: doc/rsa_operand_writer.md
Name: rsa_operand_writer

Overview:
- Write-side counterpart of the operand memories that the RSA datapath reads by address.
- Accepts a multi-word operand (modulus/message or exponent) as a stream of 32-bit words over a valid/ready handshake.
- Produces word-addressed write strobes into the selected operand memory (m or e), least-significant word first.
- Signals completion once the full operand has been written; the datapath must not begin reading before then.

Parameters:
- WIDTH, 32, data word width in bits.
- ADDR_WIDTH, 7, memory address width.
- NUM_WORDS, 128, words per operand (128 x 32 = 4096 bits); legal range 1 to 2**ADDR_WIDTH.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin loading one operand; sampled only in IDLE.
- sel  input  1  target memory, sampled with start: 0 = mem_m, 1 = mem_e.
- in_valid  input  1  in_data holds a valid word.
- in_data  input  WIDTH  operand word.
- in_ready  output  1  writer accepts a word this cycle.
- wr_en_m  output  1  write strobe to mem_m.
- wr_en_e  output  1  write strobe to mem_e.
- wr_addr  output  ADDR_WIDTH  write address.
- wr_data  output  WIDTH  write data.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse after the last word is written.

Behaviour:
- Clock is clk. Reset is synchronous and active-high on reset.
- Reset values:
  - State IDLE; in_ready, wr_en_m, wr_en_e, busy and done all 0.
  - wr_addr 0, wr_data 0, word counter 0, latched sel 0.
- States and transitions:
  - IDLE: start=1 latches sel, clears the counter and goes to LOAD.
  - LOAD: in_ready=1. A word is accepted when in_valid and in_ready are both 1.
  - LOAD, accepted word with counter = NUM_WORDS-1: go to FLUSH.
  - LOAD, accepted word otherwise: stay in LOAD.
  - FLUSH: in_ready=0 for one cycle while the last write drains, then go to DONE.
  - DONE: done=1 for exactly one cycle, then return to IDLE.
- Write path: registered, one-cycle latency.
  - A word accepted in cycle N produces, in cycle N+1, wr_en_<sel>=1 with wr_addr = counter value at N and wr_data = in_data at N.
  - Exactly one of wr_en_m/wr_en_e asserts, per the latched sel; never both.
- Counter: increments by one per accepted word and never wraps within an operand. Word k is written to address k.
- busy is 1 in LOAD, FLUSH and DONE; it is 0 in IDLE.
- Back-to-back: a word can be accepted every cycle, so a full operand takes NUM_WORDS cycles in LOAD.
- in_valid=0 stalls: no write strobe, counter holds.
- start while not IDLE is ignored; sel changes after acceptance are ignored.
- in_valid while in IDLE, FLUSH or DONE: not accepted (in_ready=0) and no write.
- start and in_valid in the same IDLE cycle: the word is not accepted; the first acceptance is possible in the following cycle.
- Reset mid-LOAD: returns to IDLE next edge.
  - Any pending write strobe is dropped.
  - Partially written memory contents are not cleared.
  - done does not pulse.
- NUM_WORDS=1: LOAD accepts a single word, then FLUSH, then DONE.

Optional Feature:
- Macro: RSA_OPERAND_WRITER_CHECKSUM_EN.
- When defined:
  - Adds output checksum [WIDTH-1:0]: the XOR of all words accepted in the current operand.
  - Cleared on start acceptance and on reset.
  - Updated on each acceptance.
  - Stable and valid in the done cycle, and held until the next start.
- When undefined: no port and no logic. Core behaviour is identical in both builds.

Decomposition:
- Shared package rsa_pkg holds:
  - constants WIDTH, ADDR_WIDTH, NUM_WORDS;
  - the state enum (IDLE, LOAD, FLUSH, DONE);
  - SEL_M=0 and SEL_E=1.
- The memory read blocks use the same constants.
- No sub-module: the FSM, counter and write register form one block of about 150-250 lines.

Test Plan:
- Full load to m:
  - Stimulus: start with sel=0, then 128 back-to-back words 32'h1000_0000+k.
  - Required: wr_en_m pulses 128 times, address k carries data 32'h1000_0000+k, wr_en_e never asserts.
  - Required: done pulses exactly once, 2 cycles after the last acceptance.
- Stalled load to e:
  - Stimulus: sel=1, in_valid toggling 1,0,0,1 pattern.
  - Required: strobes only on accepted words, addresses contiguous 0..127, no gaps or duplicates.
- Ignored inputs:
  - Stimulus: start pulsed again at word 50; in_valid asserted in IDLE and in DONE.
  - Required: no state change and no extra writes; in_ready=0 outside LOAD.
- Reset mid-load:
  - Stimulus: reset asserted after word 60.
  - Required: next cycle IDLE, busy=0, no wr_en, no done.
  - Required: a subsequent fresh load restarts at address 0.
- Boundary, build with NUM_WORDS=1:
  - Stimulus: a single word 32'hDEAD_BEEF.
  - Required: one write at address 0, done 2 cycles later.
- Checksum (RSA_OPERAND_WRITER_CHECKSUM_EN defined):
  - Stimulus: words 32'hFFFF_0000, 32'h0000_FFFF, 32'h1234_5678, then all zeros.
  - Required: checksum 32'hEDCB_A987 at done.
